bfp_normalize: RTL and testbench

Block-floating-point normalizer that sits directly downstream of the per-lane headroom detector (`mag_detect_1`). Each cycle it accepts 16 sign-extended samples plus their leading-redundant-sign-bit counts. It accumulates one frame of FRAME_LEN beats in a ping-pong buffer and tracks the minimum count over the whole frame. It then replays the frame, with every sample left-shifted by that common exponent and truncated to O_WIDTH bits, so the next FFT stage sees full-scale data plus one exponent per frame.

---
 rtl/bfp_pkg.sv | 19 +
 rtl/bfp_normalize_min_tree_16.sv | 30 +++
 rtl/bfp_normalize.sv | 160 ++++++++++++++++
 tb/tb_bfp_normalize.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point normalizer.
//   CNT_W      : width of a redundant-sign count / frame exponent
//   rd_state_t : readout FSM states
//   min_cnt    : smaller of two counts
package bfp_pkg;

    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bfp_normalize_min_tree_16.sv
// Combinational 4-level comparator tree returning the smallest of 16 counts.
// Ports:
//   cnt     in  16 x CNT_W  per-lane redundant-sign counts
//   min_out out CNT_W       minimum over all lanes
module min_tree_16
    import bfp_pkg::*;
(
    input  logic [CNT_W-1:0] cnt [16],
    output logic [CNT_W-1:0] min_out
);

    logic [CNT_W-1:0] lvl1 [8];
    logic [CNT_W-1:0] lvl2 [4];
    logic [CNT_W-1:0] lvl3 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) lvl1[i] = min_cnt(cnt[2*i], cnt[2*i+1]);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) lvl2[i] = min_cnt(lvl1[2*i], lvl1[2*i+1]);
    end

    always_comb begin
        for (int i = 0; i < 2; i++) lvl3[i] = min_cnt(lvl2[2*i], lvl2[2*i+1]);
    end

    assign min_out = min_cnt(lvl3[0], lvl3[1]);

endmodule

// File: rtl/bfp_normalize.sv
// Block-floating-point normalizer. Buffers one frame of FRAME_LEN beats in a
// ping-pong buffer while tracking the minimum redundant-sign count, then
// replays the frame with every sample shifted left by that common exponent
// and truncated to O_WIDTH bits.
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_valid  in   input beat qualifier (no backpressure)
//   din      in   DATA_WIDTH x I_WIDTH signed samples
//   i_cnt    in   DATA_WIDTH x CNT_W per-lane redundant-sign counts
//   o_valid  out  output beat qualifier
//   dout     out  DATA_WIDTH x O_WIDTH signed normalized samples
//   o_exp    out  frame exponent, constant across an output frame
//   o_sof    out  first beat of an output frame
//   o_eof    out  last beat of an output frame
module bfp_normalize
    import bfp_pkg::*;
#(
    parameter int I_WIDTH    = 25,
    parameter int O_WIDTH    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic signed [I_WIDTH-1:0] din   [DATA_WIDTH],
    input  logic        [CNT_W-1:0]   i_cnt [DATA_WIDTH],
    output logic                      o_valid,
    output logic signed [O_WIDTH-1:0] dout  [DATA_WIDTH],
    output logic        [CNT_W-1:0]   o_exp,
    output logic                      o_sof,
    output logic                      o_eof
);

    localparam int                BEAT_W    = $clog2(FRAME_LEN);
    localparam int                WORD_W    = DATA_WIDTH * I_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]  lane_min;
    logic [CNT_W-1:0]  frame_min;
    logic [CNT_W-1:0]  run_min;
    logic [CNT_W-1:0]  exp_reg [2];
    logic [CNT_W-1:0]  rd_exp;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;
    logic              wr_bank;
    logic              done_bank;
    logic              rd_bank;
    logic              rd_start;
    rd_state_t         state;

    logic [WORD_W-1:0] mem0 [FRAME_LEN];
    logic [WORD_W-1:0] mem1 [FRAME_LEN];
    logic [WORD_W-1:0] din_word;
    logic [WORD_W-1:0] rd_word;
    logic signed [O_WIDTH-1:0] norm [DATA_WIDTH];

    min_tree_16 u_min_tree (
        .cnt     (i_cnt),
        .min_out (lane_min)
    );

    // Minimum including the current beat; becomes the exponent on the last beat.
    assign frame_min = min_cnt(run_min, lane_min);

    always_comb begin
        din_word = '0;
        for (int l = 0; l < DATA_WIDTH; l++) din_word[l*I_WIDTH +: I_WIDTH] = din[l];
    end

    // Write side: beat/bank counters, running minimum and per-bank exponent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_beat    <= '0;
            wr_bank    <= 1'b0;
            run_min    <= '0;
            exp_reg[0] <= '0;
            exp_reg[1] <= '0;
            rd_start   <= 1'b0;
            done_bank  <= 1'b0;
        end else begin
            rd_start <= 1'b0;
            if (i_valid) begin
                run_min <= (wr_beat == '0) ? lane_min : frame_min;
                if (wr_beat == LAST_BEAT) begin
                    wr_beat          <= '0;
                    wr_bank          <= ~wr_bank;
                    exp_reg[wr_bank] <= frame_min;
                    rd_start         <= 1'b1;
                    done_bank        <= wr_bank;
                end else begin
                    wr_beat <= wr_beat + BEAT_W'(1);
                end
            end
        end
    end

    // Buffer storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            if (wr_bank) mem1[wr_beat] <= din_word;
            else         mem0[wr_beat] <= din_word;
        end
    end

    assign rd_word = rd_bank ? mem1[rd_beat] : mem0[rd_beat];
    assign rd_exp  = exp_reg[rd_bank];

    // Shift within I_WIDTH (cannot overflow since exp <= headroom), then keep
    // the top O_WIDTH bits; the arithmetic right shift floors toward -inf.
    always_comb begin
        for (int l = 0; l < DATA_WIDTH; l++) begin
            norm[l] = O_WIDTH'(($signed(rd_word[l*I_WIDTH +: I_WIDTH]) <<< rd_exp)
                               >>> (I_WIDTH - O_WIDTH));
        end
    end

    // Readout FSM; the buffer read and the output register share one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_beat <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_exp   <= '0;
            for (int l = 0; l < DATA_WIDTH; l++) dout[l] <= '0;
        end else begin
            o_valid <= (state == READ);
            o_sof   <= (state == READ) && (rd_beat == '0);
            o_eof   <= (state == READ) && (rd_beat == LAST_BEAT);
            if (state == READ) begin
                o_exp <= rd_exp;
                for (int l = 0; l < DATA_WIDTH; l++) dout[l] <= norm[l];
            end
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state   <= READ;
                        rd_bank <= done_bank;
                        rd_beat <= '0;
                    end
                end
                READ: begin
                    if (rd_beat == LAST_BEAT) begin
                        rd_beat <= '0;
                        // A frame completing right now chains on without a bubble.
                        if (rd_start) rd_bank <= done_bank;
                        else          state   <= IDLE;
                    end else begin
                        rd_beat <= rd_beat + BEAT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfp_normalize.sv
// Self-checking bench for bfp_normalize: directed and random frames compared
// against a frame-level arithmetic model with predicted output cycles.
module tb_bfp_normalize;
    import bfp_pkg::*;

    localparam int IW = 25;
    localparam int OW = 16;
    localparam int NL = 16;
    localparam int FL = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic signed [IW-1:0] din   [NL];
    logic [CNT_W-1:0]     i_cnt [NL];
    logic                 o_valid;
    logic signed [OW-1:0] dout  [NL];
    logic [CNT_W-1:0]     o_exp;
    logic                 o_sof;
    logic                 o_eof;

    bfp_normalize #(
        .I_WIDTH    (IW),
        .O_WIDTH    (OW),
        .DATA_WIDTH (NL),
        .FRAME_LEN  (FL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .din     (din),
        .i_cnt   (i_cnt),
        .o_valid (o_valid),
        .dout    (dout),
        .o_exp   (o_exp),
        .o_sof   (o_sof),
        .o_eof   (o_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        int                   cyc;
        logic [CNT_W-1:0]     e;
        logic                 sof;
        logic                 eof;
        logic [NL-1:0][OW-1:0] d;
    } beat_t;

    beat_t exp_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    frame_x [FL][NL];
    int    frame_c [FL][NL];

    task automatic chk(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Headroom detector model: count = (IW-1) - bit length of |x|.
    function automatic int bitlen(input int m);
        int n = 0;
        int v = m;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int cnt_of(input int x);
        return IW - 1 - bitlen((x < 0) ? -x : x);
    endfunction

    function automatic int rand_sample(input int bl);
        int m;
        if (bl == 0) return 0;
        m = (1 << (bl - 1)) | (int'($urandom) & ((1 << (bl - 1)) - 1));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    task automatic set_counts();
        for (int b = 0; b < FL; b++)
            for (int l = 0; l < NL; l++) frame_c[b][l] = cnt_of(frame_x[b][l]);
    endtask

    task automatic fill_const(input int v);
        for (int b = 0; b < FL; b++)
            for (int l = 0; l < NL; l++) frame_x[b][l] = v;
        set_counts();
    endtask

    task automatic fill_mixed();
        for (int b = 0; b < FL; b++)
            for (int l = 0; l < NL; l++) frame_x[b][l] = 1;
        frame_x[9][5] = -4096;
        set_counts();
    endtask

    // Largest magnitude has exactly maxbl bits, so frame exponent = 24 - maxbl.
    task automatic fill_random(input int maxbl);
        for (int b = 0; b < FL; b++)
            for (int l = 0; l < NL; l++) frame_x[b][l] = rand_sample($urandom_range(0, maxbl));
        frame_x[$urandom_range(0, FL-1)][$urandom_range(0, NL-1)] = rand_sample(maxbl);
        set_counts();
    endtask

    // Reference: exponent is the frame-wide minimum count; each output is
    // floor(x * 2^e / 2^(IW-OW)). Beat j appears at edge t+2+j.
    task automatic push_expected(input int t);
        int    e = IW;
        beat_t bt;
        for (int b = 0; b < FL; b++)
            for (int l = 0; l < NL; l++)
                if (frame_c[b][l] < e) e = frame_c[b][l];
        for (int j = 0; j < FL; j++) begin
            bt     = '0;
            bt.cyc = t + 2 + j;
            bt.e   = CNT_W'(e);
            bt.sof = (j == 0);
            bt.eof = (j == FL - 1);
            for (int l = 0; l < NL; l++) begin
                longint p;
                p = longint'(frame_x[j][l]) * (longint'(1) << e);
                p = p >>> (IW - OW);
                bt.d[l] = p[OW-1:0];
            end
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_idle();
        i_valid = 1'b0;
        for (int l = 0; l < NL; l++) begin
            din[l]   = IW'($urandom);
            i_cnt[l] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_idle();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_exp",   longint'(o_exp),   0);
        chk("rst_sof",   longint'(o_sof),   0);
        chk("rst_dout5", longint'(dout[5]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int abort_at);
        for (int b = 0; b < FL; b++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
                drive_idle();
            end
            if (b == abort_at) begin
                do_reset();
                return;
            end
            @(posedge clk);
            #1;
            i_valid = 1'b1;
            for (int l = 0; l < NL; l++) begin
                din[l]   = IW'(frame_x[b][l]);
                i_cnt[l] = CNT_W'(frame_c[b][l]);
            end
            if (b == FL - 1) push_expected(cyc + 1);
        end
    endtask

    always @(negedge clk) begin
        beat_t bt;
        if (!rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", longint'(o_valid), 0);
                end else begin
                    bt = exp_q.pop_front();
                    chk("beat_cycle", cyc, bt.cyc);
                    chk("o_exp", longint'(o_exp), longint'(bt.e));
                    chk("o_sof", longint'(o_sof), longint'(bt.sof));
                    chk("o_eof", longint'(o_eof), longint'(bt.eof));
                    for (int l = 0; l < NL; l++)
                        chk($sformatf("dout[%0d]", l), longint'(dout[l]),
                            longint'($signed(bt.d[l])));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                bt = exp_q.pop_front();
                chk("beat_valid", longint'(o_valid), 1);
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", longint'(o_valid), 0);
        chk("reset_exp",   longint'(o_exp),   0);
        chk("reset_eof",   longint'(o_eof),   0);
        chk("reset_dout0", longint'(dout[0]), 0);

        fill_const(1);      send_frame(0, -1); idle(5);
        fill_mixed();       send_frame(0, -1); idle(3);
        fill_const(0);      send_frame(0, -1); idle(2);

        fill_random(21);    send_frame(0, -1);
        fill_random(7);     send_frame(0, -1); idle(1);

        for (int k = 0; k < 6; k++) begin
            fill_random($urandom_range(0, 24));
            send_frame(30, -1);
            idle($urandom_range(0, 3));
        end

        fill_random(15);    send_frame(0, -1);
        fill_random(10);    send_frame(0, 12);
        fill_random(20);    send_frame(10, -1);
        idle(1);

        w = 0;
        while (exp_q.size() > 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        chk("drain_left", longint'(exp_q.size()), 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
